// File: rtl/display_pkg.sv
// Shared constants, scan state type and digit lane helpers for the 4-digit display scheduler.
package display_pkg;

  localparam logic [1:0] GNT_STATUS = 2'd0;
  localparam logic [1:0] GNT_MENU   = 2'd1;
  localparam logic [1:0] GNT_ALERT  = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } scan_state_e;

  // Digit n takes byte lane n of a 32-bit frame; digit0 is the low byte.
  function automatic logic [7:0] digit_lane(input logic [31:0] frame, input logic [1:0] digit);
    return frame[8*digit +: 8];
  endfunction

  function automatic logic [3:0] digit_an(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Frame sources on one side, alert status and the board an/seg pins on the other.
interface display_scheduler_if;

  logic [31:0] stat_frame;
  logic        menu_req;
  logic [31:0] menu_frame;
  logic        alert_req;
  logic [31:0] alert_frame;
  logic        alert_busy;
  logic [1:0]  grant;
  logic        frame_start;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output stat_frame, menu_req, menu_frame, alert_req, alert_frame,
    input  alert_busy, grant, frame_start, an, seg
  );

  modport slave (
    input  stat_frame, menu_req, menu_frame, alert_req, alert_frame,
    output alert_busy, grant, frame_start, an, seg
  );

endinterface

// File: rtl/scan_tick.sv
// Digit-slot prescaler: tick on the last cycle of each slot, blank_done on the last blank cycle.
module scan_tick #(
  parameter int unsigned CLK_DIV   = 200000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic blank_done
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(BLANK_CYC + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_END  = BW'(BLANK_CYC);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blank_q, blank_d;

  assign tick       = (pre_q == PRE_LAST);
  assign blank_done = (blank_q == BLANK_LAST);

  // The blank counter parks at BLANK_END so the display stays dark until the first tick.
  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    blank_d = blank_q;
    if (tick) begin
      blank_d = '0;
    end else if (blank_q != BLANK_END) begin
      blank_d = blank_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      blank_q <= BLANK_END;
    end else begin
      pre_q   <= pre_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates alert/menu/status frames onto a scanned 4-digit 7-segment display, switching
// content only at frame boundaries and blanking the start of each digit slot.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 200000,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned HOLD_FRAMES = 125
) (
  input logic                clk,
  input logic                rst_n,
  display_scheduler_if.slave bus
);

  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES - 1);

  logic tick, blank_done, boundary;

  scan_state_e   state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [31:0]   snap_q, snap_d;
  logic [31:0]   latch_q, latch_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    grant_q, grant_d;
  logic          fs_q, fs_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  scan_tick #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .blank_done (blank_done)
  );

  assign boundary = tick && (digit_q == 2'd3);

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    snap_d  = snap_q;
    latch_d = latch_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    fs_d    = boundary;

    if (tick) begin
      digit_d = digit_q + 2'd1;
      state_d = S_BLANK;
    end else if (state_q == S_BLANK && blank_done) begin
      state_d = S_SHOW;
    end

    if (boundary) begin
      if (pend_q) begin
        grant_d = GNT_ALERT;
        snap_d  = latch_q;
        hold_d  = HOLD_INIT;
        pend_d  = 1'b0;
      end else if (hold_q != '0) begin
        grant_d = GNT_ALERT;
        hold_d  = hold_q - 1'b1;
      end else if (bus.menu_req) begin
        grant_d = GNT_MENU;
        snap_d  = bus.menu_frame;
      end else begin
        grant_d = GNT_STATUS;
        snap_d  = bus.stat_frame;
      end
    end

    // A pulse in a boundary cycle is kept pending for the following boundary.
    if (bus.alert_req) begin
      pend_d  = 1'b1;
      latch_d = bus.alert_frame;
    end

    // Outputs follow the next state so an/seg change on the same edge as the scan FSM.
    unique case (state_d)
      S_SHOW: begin
        an_d  = digit_an(digit_d);
        seg_d = digit_lane(snap_d, digit_d);
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      digit_q <= 2'd3;
      snap_q  <= 32'hFFFF_FFFF;
      latch_q <= 32'hFFFF_FFFF;
      pend_q  <= 1'b0;
      hold_q  <= '0;
      grant_q <= GNT_STATUS;
      fs_q    <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      latch_q <= latch_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      fs_q    <= fs_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.grant       = grant_q;
  assign bus.frame_start = fs_q;
  assign bus.alert_busy  = pend_q | (hold_q != '0) | (grant_q == GNT_ALERT);

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the 4-digit, active-low 7-segment display between three frame sources, in fixed priority: transient alerts, menu/edit screens, and the default playback status.
- Owns digit scanning.
- Inserts a blanking gap between digits to suppress ghosting.
- Switches source or content only at frame boundaries, so no digit ever shows mixed content.
- Sits between the status/menu/alert frame generators and the board an/seg pins.

Parameters:
- CLK_DIV, 200000: clk cycles per digit slot, about 250 Hz at 50 MHz.
- BLANK_CYC, 1000: cycles at the start of each slot with all digits off. Legal range is 1 to CLK_DIV-1.
- HOLD_FRAMES, 125: number of full 4-digit frames an alert stays on screen, about 2 s. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stat_frame  in  32  status segments. [7:0] drives digit0 (an[0]), [31:24] drives digit3 (an[3]). Active-low segments with DP in bit 7.
- menu_req  in  1  level; high requests the menu screen
- menu_frame  in  32  menu segments, same layout as stat_frame
- alert_req  in  1  single-cycle pulse requesting an alert
- alert_frame  in  32  alert segments; sampled in the cycle alert_req is high
- alert_busy  out  1  an alert is pending or on screen
- grant  out  2  source currently displayed: 0 = status, 1 = menu, 2 = alert
- frame_start  out  1  one-cycle pulse at each frame boundary
- an  out  4  digit enables, active-low
- seg  out  8  segment drive, active-low

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: an=4'hF, seg=8'hFF, grant=0, frame_start=0, alert_busy=0.
  - Internal: prescaler=0, digit=3, state=S_BLANK, snapshot=32'hFFFFFFFF, pending=0, hold=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is asserted in the cycle the count equals CLK_DIV-1.
- Digit index:
  - Increments on tick and wraps 3 to 0.
  - A tick that moves the index from 3 to 0 is a frame boundary.
  - Because digit resets to 3, the first tick after reset is a boundary.
- Scan FSM, two states:
  - S_BLANK: an=4'hF, seg=8'hFF. Entered on every tick, with the blank counter cleared. Moves to S_SHOW after exactly BLANK_CYC cycles.
  - S_SHOW: an=~(1<<digit), seg=snapshot[8*digit +: 8]. Held until the next tick.
  - an and seg are registered; no other states exist.
- Frame boundary actions, all in the boundary cycle:
  - If pending=1: grant<=2, snapshot<=alert latch, hold<=HOLD_FRAMES-1, pending<=0.
  - Else if hold!=0: grant<=2, hold<=hold-1, snapshot unchanged.
  - Else if menu_req=1: grant<=1, snapshot<=menu_frame.
  - Else: grant<=0, snapshot<=stat_frame.
  - frame_start<=1 for one cycle.
  - Net effect: an alert occupies exactly HOLD_FRAMES frames.
- Inputs between boundaries:
  - stat_frame and menu_frame changes mid-frame have no visible effect until the next boundary.
  - Toggling menu_req mid-frame has no visible effect until the next boundary.
- Alert capture:
  - Every alert_req pulse sets pending and latches alert_frame.
  - A pulse arriving in a boundary cycle is captured and granted at the following boundary, not the current one.
  - Retrigger: a pulse while an alert is shown overwrites the latch. From the next boundary the new alert runs a fresh HOLD_FRAMES frames.
- alert_busy = pending | (hold!=0) | (grant==2). Registered-derived; it falls in the first boundary after the alert's last frame.
- Widths:
  - hold is $clog2(HOLD_FRAMES) bits, minimum 1.
  - The prescaler and blank counter are sized from their parameters.
  - All counts are unsigned and never saturate beyond the stated wraps.

Decomposition:
- Shared package display_pkg holds:
  - GNT_STATUS=2'd0, GNT_MENU=2'd1, GNT_ALERT=2'd2
  - SEG_BLANK=8'hFF
  - AN_OFF=4'hF
  - the digit-to-byte lane mapping
- One sub-module, scan_tick: a resettable prescaler producing tick and the blank-phase done flag, parameterised by CLK_DIV and BLANK_CYC.

Test Plan:
All scenarios use CLK_DIV=8, BLANK_CYC=2, HOLD_FRAMES=3.
1. Reset then scan:
   - Stimulus: stat_frame=32'hC0F9A4B0.
   - Required: an=F and seg=FF until the first tick (cycle 7 after reset release). frame_start is high for 1 cycle. an=F for 2 cycles, then an=1110/seg=B0 for 6 cycles, then 1101/A4, 1011/F9, 0111/C0. The sequence repeats.
2. No tearing:
   - Stimulus: change stat_frame to 32'h8E8E8E8E while digit1 is shown.
   - Required: digits 2 and 3 still show F9 and C0. 8E appears only after the next frame_start.
3. Menu priority:
   - Stimulus: menu_req=1 with menu_frame=32'h88888888 mid-frame.
   - Required: grant=1 and seg=88 from the next boundary. After menu_req drops, grant=0 at the following boundary.
4. Alert hold over menu:
   - Stimulus: menu_req held high; 1-cycle alert_req with alert_frame=32'h86868686.
   - Required: alert_busy=1 the next cycle. grant=2 for exactly 3 frames. grant=1 at the 4th boundary, where alert_busy falls.
5. Retrigger:
   - Stimulus: a second alert_req (frame 32'h92929292) during the alert's 2nd frame.
   - Required: 92 shown from the next boundary for 3 full frames; 5 alert frames in total.
6. Reset mid-operation:
   - Stimulus: drop rst_n during S_SHOW with an alert pending.
   - Required: an=F and seg=FF in the same cycle (asynchronous). On release: grant=0, alert_busy=0, no alert shown.
